macc_1_to_n_accum: RTL

//  Parametrised 1-to-N multiply-accumulate: one shared vector (input_common) is dot-multiplied against NUM_MACC

---
 rtl/macc_1_to_n_accum_pkg.sv | 46 ++++
 rtl/macc_1_to_n_accum_mult.sv | 59 +++++
 rtl/macc_1_to_n_accum.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/macc_1_to_n_accum_pkg.sv
// Shared types and width arithmetic for the 1-to-N multiply-accumulate block.
// Every width below is derived from the operand width, the dot length and the group length.
package macc_1_to_n_accum_pkg;

  localparam int MULT_STAGES = 3;

  // Control that travels down the pipeline alongside each beat.
  typedef struct packed {
    logic valid;
    logic last;
    logic err;
  } beat_tag_t;

  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int calc_prod_w(input int data_width);
    return 2 * data_width;
  endfunction

  function automatic int calc_tree_w(input int data_width, input int num_inputs);
    return calc_prod_w(data_width) + $clog2(num_inputs);
  endfunction

  // Wide enough for MAX_BEATS dot products of the most negative operands squared.
  function automatic int calc_out_w(input int data_width, input int num_inputs,
                                    input int max_beats);
    return calc_tree_w(data_width, num_inputs) + $clog2(max_beats);
  endfunction

  function automatic int calc_latency(input int num_inputs);
    return MULT_STAGES + $clog2(num_inputs) + 1;
  endfunction

  // Nodes left after 'level' rounds of pairwise reduction, odd node passed through.
  function automatic int tree_nodes(input int num_leaves, input int level);
    int count;
    count = num_leaves;
    for (int i = 0; i < level; i++) begin
      count = (count + 1) / 2;
    end
    return count;
  endfunction

endpackage

// File: rtl/macc_1_to_n_accum_mult.sv
// Three-stage signed multiplier array: operand register, multiply register, product register.
// Datapath registers load only when their stage holds a valid beat; only the tags are reset.
module macc_mult_array
  import macc_1_to_n_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  beat_tag_t                           in_tag,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]    a,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]    b,
  output logic [2*DATA_WIDTH*NUM_INPUTS-1:0]  prod,
  output beat_tag_t                           out_tag
);

  localparam int PROD_W = calc_prod_w(DATA_WIDTH);

  logic signed [DATA_WIDTH-1:0] a_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0] b_q [NUM_INPUTS];
  (* use_dsp = "yes" *) logic signed [PROD_W-1:0] mul_q [NUM_INPUTS];
  beat_tag_t tag_q [MULT_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MULT_STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < MULT_STAGES; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_tag.valid) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        a_q[j] <= a[j*DATA_WIDTH +: DATA_WIDTH];
        b_q[j] <= b[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (tag_q[0].valid) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        mul_q[j] <= PROD_W'(a_q[j]) * PROD_W'(b_q[j]);
      end
    end
    if (tag_q[1].valid) begin
      for (int j = 0; j < NUM_INPUTS; j++) begin
        prod[j*PROD_W +: PROD_W] <= mul_q[j];
      end
    end
  end

  assign out_tag = tag_q[MULT_STAGES-1];

endmodule

// File: rtl/macc_1_to_n_accum.sv
// 1-to-N MACC: shared vector dotted with NUM_MACC channel vectors, registered adder tree,
// then multi-beat accumulation closed by i_last or force-closed (with o_err) at MAX_BEATS.
module macc_1_to_n_accum
  import macc_1_to_n_accum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 9,
  parameter int NUM_MACC   = 5,
  parameter int MAX_BEATS  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [DATA_WIDTH*NUM_INPUTS*NUM_MACC-1:0]     input_n,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0]              input_common,
  input  logic                                          i_valid,
  input  logic                                          i_last,
  output logic [calc_out_w(DATA_WIDTH, NUM_INPUTS, MAX_BEATS)*NUM_MACC-1:0] o_data,
  output logic                                          o_valid,
  output logic                                          o_err
);

  localparam int PROD_W = calc_prod_w(DATA_WIDTH);
  localparam int TREE_L = $clog2(NUM_INPUTS);
  localparam int TREE_W = calc_tree_w(DATA_WIDTH, NUM_INPUTS);
  localparam int OUT_W  = calc_out_w(DATA_WIDTH, NUM_INPUTS, MAX_BEATS);
  localparam int BEAT_W = clog2_min1(MAX_BEATS);
  localparam int HALF_N = (NUM_INPUTS + 1) / 2;
  localparam int VEC_W  = DATA_WIDTH * NUM_INPUTS;

  logic [BEAT_W-1:0]           beat_cnt;
  logic                        at_limit;
  logic                        group_open;
  beat_tag_t                   in_tag;
  beat_tag_t                   mult_tag;
  beat_tag_t                   sum_tag;
  beat_tag_t                   mtag     [NUM_MACC];
  logic [PROD_W*NUM_INPUTS-1:0] prod    [NUM_MACC];
  logic signed [TREE_W-1:0]    sum_in   [NUM_MACC];
  logic signed [OUT_W-1:0]     sum_ext  [NUM_MACC];
  logic signed [OUT_W-1:0]     acc_q    [NUM_MACC];
  logic signed [OUT_W-1:0]     acc_next [NUM_MACC];

  // A beat closes its group on i_last or when it is the MAX_BEATS-th beat.
  always_comb begin
    at_limit     = (beat_cnt == BEAT_W'(MAX_BEATS - 1));
    in_tag.valid = i_valid;
    in_tag.last  = i_valid & (i_last | at_limit);
    in_tag.err   = i_valid & at_limit & ~i_last & (MAX_BEATS > 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (i_valid) begin
      beat_cnt <= in_tag.last ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_MACC; k++) begin : g_mult
    macc_mult_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_INPUTS (NUM_INPUTS)
    ) u_mult (
      .clk     (clk),
      .rst     (rst),
      .in_tag  (in_tag),
      .a       (input_n[k*VEC_W +: VEC_W]),
      .b       (input_common),
      .prod    (prod[k]),
      .out_tag (mtag[k])
    );
  end

  // All channel arrays run in lockstep, so their tags agree.
  always_comb begin
    mult_tag.valid = 1'b1;
    mult_tag.last  = 1'b0;
    mult_tag.err   = 1'b0;
    for (int k = 0; k < NUM_MACC; k++) begin
      mult_tag.valid = mult_tag.valid & mtag[k].valid;
      mult_tag.last  = mult_tag.last  | mtag[k].last;
      mult_tag.err   = mult_tag.err   | mtag[k].err;
    end
  end

  if (TREE_L == 0) begin : g_no_tree
    always_comb begin
      sum_tag = mult_tag;
      for (int k = 0; k < NUM_MACC; k++) begin
        sum_in[k] = TREE_W'($signed(prod[k][PROD_W-1:0]));
      end
    end
  end else begin : g_tree
    beat_tag_t                tree_tag [TREE_L];
    logic                     layer_en [TREE_L];
    logic signed [TREE_W-1:0] lvl_in   [NUM_MACC][TREE_L][NUM_INPUTS];
    logic signed [TREE_W-1:0] tree_q   [NUM_MACC][TREE_L][HALF_N];

    // Every layer works at full tree width; sign extension keeps the sums exact.
    always_comb begin
      layer_en[0] = mult_tag.valid;
      for (int l = 1; l < TREE_L; l++) begin
        layer_en[l] = tree_tag[l-1].valid;
      end
      for (int k = 0; k < NUM_MACC; k++) begin
        for (int j = 0; j < NUM_INPUTS; j++) begin
          lvl_in[k][0][j] = TREE_W'($signed(prod[k][j*PROD_W +: PROD_W]));
        end
        for (int l = 1; l < TREE_L; l++) begin
          for (int j = 0; j < HALF_N; j++) begin
            lvl_in[k][l][j] = tree_q[k][l-1][j];
          end
          for (int j = HALF_N; j < NUM_INPUTS; j++) begin
            lvl_in[k][l][j] = '0;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int l = 0; l < TREE_L; l++) begin
          tree_tag[l] <= '0;
        end
      end else begin
        tree_tag[0] <= mult_tag;
        for (int l = 1; l < TREE_L; l++) begin
          tree_tag[l] <= tree_tag[l-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int l = 0; l < TREE_L; l++) begin
        if (layer_en[l]) begin
          for (int k = 0; k < NUM_MACC; k++) begin
            for (int n = 0; n < HALF_N; n++) begin
              if (n < tree_nodes(NUM_INPUTS, l + 1)) begin
                if (2*n + 1 < tree_nodes(NUM_INPUTS, l)) begin
                  tree_q[k][l][n] <= lvl_in[k][l][2*n] +
                                     lvl_in[k][l][(2*n + 1 < NUM_INPUTS) ? 2*n + 1 : 2*n];
                end else begin
                  tree_q[k][l][n] <= lvl_in[k][l][2*n];
                end
              end
            end
          end
        end
      end
    end

    always_comb begin
      sum_tag = tree_tag[TREE_L-1];
      for (int k = 0; k < NUM_MACC; k++) begin
        sum_in[k] = tree_q[k][TREE_L-1][0];
      end
    end
  end

  // The first beat after a closed group loads; later beats add.
  always_comb begin
    for (int k = 0; k < NUM_MACC; k++) begin
      sum_ext[k]  = OUT_W'(sum_in[k]);
      acc_next[k] = group_open ? acc_q[k] + sum_ext[k] : sum_ext[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      group_open <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_data     <= '0;
      for (int k = 0; k < NUM_MACC; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      o_valid <= sum_tag.valid & sum_tag.last;
      o_err   <= sum_tag.valid & sum_tag.last & sum_tag.err;
      if (sum_tag.valid) begin
        group_open <= ~sum_tag.last;
        for (int k = 0; k < NUM_MACC; k++) begin
          acc_q[k] <= acc_next[k];
          if (sum_tag.last) begin
            o_data[k*OUT_W +: OUT_W] <= acc_next[k];
          end
        end
      end
    end
  end

endmodule
